// File: rtl/bfly_pair_feeder_if.sv
// rtl/bfly_pair_feeder_if.sv - sample-in / operand-pair-out handshake bundle for bfly_pair_feeder
interface bfly_pair_feeder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_sof;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_in0;
  logic [DATA_WIDTH-1:0] m_in1;
  logic                  m_last;

  modport master (
    output s_valid, s_data, s_sof, m_ready,
    input  s_ready, m_valid, m_in0, m_in1, m_last
  );

  modport slave (
    input  s_valid, s_data, s_sof, m_ready,
    output s_ready, m_valid, m_in0, m_in1, m_last
  );
endinterface

// File: rtl/bfly_pair_feeder.sv
// rtl/bfly_pair_feeder.sv - pairs x[k] with x[k+N/2] for the butterfly; BFLY_FEED_BLKCNT_EN adds blk_cnt
module bfly_pair_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bfly_pair_feeder_if.slave    io,
`ifdef BFLY_FEED_BLKCNT_EN
  output logic [15:0]          blk_cnt,
`endif
  output logic                 err_sync
);
  localparam int HALF = N / 2;
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic [DATA_WIDTH-1:0] buf_q [HALF];
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [DATA_WIDTH-1:0] m_in0_q;
  logic [DATA_WIDTH-1:0] m_in1_q;
  logic                  err_sync_q;
  logic                  s_ready;
  logic                  accept;
  logic [KW-1:0]         k_d;

  // PAIR may only take a beat when the output register is free or draining this cycle.
  assign s_ready = rst ? 1'b0 : ((state_q == FILL) || !m_valid_q || io.m_ready);
  assign accept  = io.s_valid && s_ready;
  assign k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      k_q        <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_in0_q    <= '0;
      m_in1_q    <= '0;
      err_sync_q <= 1'b0;
    end else begin
      err_sync_q <= 1'b0;
      if (m_valid_q && io.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
      if (accept) begin
        if (io.s_sof) begin
          // Restart: this beat becomes x[0]; any registered pair is left to drain.
          buf_q[0]   <= io.s_data;
          err_sync_q <= !((state_q == FILL) && (k_q == '0));
          if (HALF == 1) begin
            state_q <= PAIR;
            k_q     <= '0;
          end else begin
            state_q <= FILL;
            k_q     <= KW'(1);
          end
        end else if (state_q == FILL) begin
          buf_q[k_q] <= io.s_data;
          k_q        <= k_d;
          if (k_q == K_LAST) state_q <= PAIR;
        end else begin
          m_in0_q   <= buf_q[k_q];
          m_in1_q   <= io.s_data;
          m_valid_q <= 1'b1;
          m_last_q  <= (k_q == K_LAST);
          k_q       <= k_d;
          if (k_q == K_LAST) state_q <= FILL;
        end
      end
    end
  end

`ifdef BFLY_FEED_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (m_valid_q && io.m_ready && m_last_q) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

  assign io.s_ready = s_ready;
  assign io.m_valid = m_valid_q;
  assign io.m_in0   = m_in0_q;
  assign io.m_in1   = m_in1_q;
  assign io.m_last  = m_last_q;
  assign err_sync   = err_sync_q;
endmodule
